// File: rtl/rc4_key_search_sequencer_pkg.sv
// rtl/rc4_key_search_sequencer_pkg.sv - shared types for the RC4 key search sequencer
package rc4_seq_pkg;

  localparam int KEY_BYTES = 3;

  typedef enum logic [3:0] {
    IDLE,
    RST_PHASES,
    INIT_RUN,
    KSA_RUN,
    PRGA_RUN,
    CHECK,
    NEXT_KEY,
    FOUND,
    FAIL
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    INIT,
    KSA,
    PRGA
  } grant_e;

  // Memory ownership follows the RUN state the sequencer is about to occupy.
  function automatic grant_e grant_for(input state_e s);
    case (s)
      INIT_RUN: return INIT;
      KSA_RUN:  return KSA;
      PRGA_RUN: return PRGA;
      default:  return NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_key_search_sequencer_if.sv
// rtl/rc4_key_search_sequencer_if.sv - phase handshake, S-memory bus and status bundle
// SEQ_WATCHDOG_EN adds the timeout status bit.
interface rc4_key_search_sequencer_if #(
  parameter int KEY_BITS = 24
);
  logic                start;
  logic                init_finish, ksa_finish, prga_finish;
  logic                prga_valid;
  logic [7:0]          init_addr, ksa_addr, prga_addr;
  logic [7:0]          init_data, ksa_data, prga_data;
  logic                init_wren, ksa_wren, prga_wren;
  logic [7:0]          s_addr;
  logic [7:0]          s_data;
  logic                s_wren;
  logic                init_start, ksa_start, prga_start;
  logic                phase_rst;
  logic [KEY_BITS-1:0] secret_key;
  logic                busy;
  logic                found;
  logic                exhausted;
`ifdef SEQ_WATCHDOG_EN
  logic                timeout;
`endif

  modport master (
    input  start, init_finish, ksa_finish, prga_finish, prga_valid,
           init_addr, ksa_addr, prga_addr, init_data, ksa_data, prga_data,
           init_wren, ksa_wren, prga_wren,
`ifdef SEQ_WATCHDOG_EN
    output timeout,
`endif
    output s_addr, s_data, s_wren, init_start, ksa_start, prga_start,
           phase_rst, secret_key, busy, found, exhausted
  );

  modport slave (
    output start, init_finish, ksa_finish, prga_finish, prga_valid,
           init_addr, ksa_addr, prga_addr, init_data, ksa_data, prga_data,
           init_wren, ksa_wren, prga_wren,
`ifdef SEQ_WATCHDOG_EN
    input  timeout,
`endif
    input  s_addr, s_data, s_wren, init_start, ksa_start, prga_start,
           phase_rst, secret_key, busy, found, exhausted
  );

endinterface

// File: rtl/rc4_key_search_sequencer_smem_arbiter.sv
// rtl/rc4_key_search_sequencer_smem_arbiter.sv - combinational 3:1 S-memory port mux
module rc4_smem_arbiter
  import rc4_seq_pkg::*;
(
  input  grant_e     grant_i,
  input  logic [7:0] init_addr_i, ksa_addr_i, prga_addr_i,
  input  logic [7:0] init_data_i, ksa_data_i, prga_data_i,
  input  logic       init_wren_i, ksa_wren_i, prga_wren_i,
  output logic [7:0] s_addr_o,
  output logic [7:0] s_data_o,
  output logic       s_wren_o
);

  always_comb begin
    s_addr_o = 8'h00;
    s_data_o = 8'h00;
    s_wren_o = 1'b0;
    case (grant_i)
      INIT: begin
        s_addr_o = init_addr_i;
        s_data_o = init_data_i;
        s_wren_o = init_wren_i;
      end
      KSA: begin
        s_addr_o = ksa_addr_i;
        s_data_o = ksa_data_i;
        s_wren_o = ksa_wren_i;
      end
      PRGA: begin
        s_addr_o = prga_addr_i;
        s_data_o = prga_data_i;
        s_wren_o = prga_wren_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_key_search_sequencer.sv
// rtl/rc4_key_search_sequencer.sv - sequences S-init, KSA and PRGA per candidate key
// SEQ_WATCHDOG_EN enables a per-phase cycle watchdog that aborts to FAIL.
module rc4_key_search_sequencer
  import rc4_seq_pkg::*;
#(
  parameter int                KEY_BITS        = 24,
  parameter logic [KEY_BITS-1:0] KEY_MAX       = 24'h3FFFFF,
  parameter int                WATCHDOG_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            reset,
  rc4_key_search_sequencer_if.master      bus
);

  state_e              state_q, state_d;
  grant_e              grant_q;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic                wd_fire;

`ifdef SEQ_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
  logic        in_run;

  assign in_run  = (state_q == INIT_RUN) || (state_q == KSA_RUN) || (state_q == PRGA_RUN);
  assign wd_fire = in_run && (wd_q == 16'(WATCHDOG_CYCLES - 1));
  // Restarts at zero on any state change, so each RUN state gets a fresh budget.
  assign wd_d    = (state_d != state_q) ? 16'd0 : wd_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= NONE;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_for(state_d);
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    bus.phase_rst  = 1'b0;
    bus.init_start = 1'b0;
    bus.ksa_start  = 1'b0;
    bus.prga_start = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    timeout_d      = timeout_q;
`endif
    case (state_q)
      IDLE, FOUND, FAIL: begin
        if (bus.start) begin
          state_d = RST_PHASES;
          key_d   = '0;
`ifdef SEQ_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end
      RST_PHASES: begin
        bus.phase_rst = 1'b1;
        state_d       = INIT_RUN;
      end
      INIT_RUN: begin
        bus.init_start = 1'b1;
        if (bus.init_finish) state_d = KSA_RUN;
      end
      KSA_RUN: begin
        bus.ksa_start = 1'b1;
        if (bus.ksa_finish) state_d = PRGA_RUN;
      end
      PRGA_RUN: begin
        bus.prga_start = 1'b1;
        if (bus.prga_finish) state_d = CHECK;
      end
      CHECK: begin
        if (bus.prga_valid)      state_d = FOUND;
        else if (key_q == KEY_MAX) state_d = FAIL;
        else                     state_d = NEXT_KEY;
      end
      NEXT_KEY: begin
        key_d   = key_q + 1'b1;
        state_d = RST_PHASES;
      end
      default: state_d = IDLE;
    endcase
    // The phase's own finish wins a tie with the watchdog limit.
    if (wd_fire && (state_d == state_q)) begin
      state_d = FAIL;
`ifdef SEQ_WATCHDOG_EN
      timeout_d = 1'b1;
`endif
    end
  end

  assign bus.secret_key = key_q;
  assign bus.busy       = !((state_q == IDLE) || (state_q == FOUND) || (state_q == FAIL));
  assign bus.found      = (state_q == FOUND);
  assign bus.exhausted  = (state_q == FAIL);

  rc4_smem_arbiter u_arb (
    .grant_i     (grant_q),
    .init_addr_i (bus.init_addr),
    .ksa_addr_i  (bus.ksa_addr),
    .prga_addr_i (bus.prga_addr),
    .init_data_i (bus.init_data),
    .ksa_data_i  (bus.ksa_data),
    .prga_data_i (bus.prga_data),
    .init_wren_i (bus.init_wren),
    .ksa_wren_i  (bus.ksa_wren),
    .prga_wren_i (bus.prga_wren),
    .s_addr_o    (bus.s_addr),
    .s_data_o    (bus.s_data),
    .s_wren_o    (bus.s_wren)
  );

endmodule

// File: tb/tb_rc4_key_search_sequencer.sv
// tb/tb_rc4_key_search_sequencer.sv - directed bench for rc4_key_search_sequencer
// Phase FSMs are stand-ins that raise finish three start cycles after being launched.
module tb_rc4_key_search_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rc4_key_search_sequencer_if #(.KEY_BITS(24)) bus ();

  rc4_key_search_sequencer #(
    .KEY_BITS        (24),
    .KEY_MAX         (24'd3),
    .WATCHDOG_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic        model_en  = 1'b1;
  logic        ksa_block = 1'b0;
  logic        ksa_force = 1'b0;
  logic        valid_en  = 1'b0;
  logic [23:0] valid_key = 24'd0;

  int   icnt, kcnt, pcnt;
  logic ifin, kfin, pfin;

  always @(posedge clk) begin
    if (reset || bus.phase_rst) begin
      icnt <= 0; kcnt <= 0; pcnt <= 0;
      ifin <= 1'b0; kfin <= 1'b0; pfin <= 1'b0;
    end else if (model_en) begin
      if (bus.init_start && !ifin) begin
        icnt <= icnt + 1;
        if (icnt == 2) ifin <= 1'b1;
      end
      if (bus.ksa_start && !kfin && !ksa_block) begin
        kcnt <= kcnt + 1;
        if (kcnt == 2) kfin <= 1'b1;
      end
      if (bus.prga_start && !pfin) begin
        pcnt <= pcnt + 1;
        if (pcnt == 2) pfin <= 1'b1;
      end
    end
  end

  assign bus.init_finish = ifin;
  assign bus.ksa_finish  = kfin | ksa_force;
  assign bus.prga_finish = pfin;
  assign bus.prga_valid  = valid_en && (bus.secret_key == valid_key);

  int   cyc = 0;
  int   prst_cnt = 0;
  int   t_init = 0, t_ksa = 0, t_prga = 0, t_fail = 0;
  logic pi = 1'b0, pk = 1'b0, pp = 1'b0, pe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.phase_rst) prst_cnt = prst_cnt + 1;
    if (bus.init_start && !pi) t_init = cyc;
    if (bus.ksa_start && !pk)  t_ksa  = cyc;
    if (bus.prga_start && !pp) t_prga = cyc;
    if (bus.exhausted && !pe)  t_fail = cyc;
    pi = bus.init_start;
    pk = bus.ksa_start;
    pp = bus.prga_start;
    pe = bus.exhausted;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  int p0;

  initial begin
    bus.start = 1'b0;
    bus.init_addr = 8'h00; bus.ksa_addr = 8'h00; bus.prga_addr = 8'h00;
    bus.init_data = 8'h00; bus.ksa_data = 8'h00; bus.prga_data = 8'h00;
    bus.init_wren = 1'b0;  bus.ksa_wren = 1'b0;  bus.prga_wren = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_found", {31'd0, bus.found}, 32'd0);
    chk("rst_exh", {31'd0, bus.exhausted}, 32'd0);
    chk("rst_key", {8'd0, bus.secret_key}, 32'd0);
    chk("rst_swren", {31'd0, bus.s_wren}, 32'd0);
    chk("rst_prst", {31'd0, bus.phase_rst}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single key, valid on key 0
    valid_en = 1'b1; valid_key = 24'd0;
    p0 = prst_cnt;
    pulse_start();
    for (int i = 0; i < 200 && !bus.found; i++) @(negedge clk);
    chk("k0_found", {31'd0, bus.found}, 32'd1);
    chk("k0_key", {8'd0, bus.secret_key}, 32'd0);
    chk("k0_prst", prst_cnt - p0, 32'd1);
    chk("k0_ksa_after_init", t_ksa - t_init, 32'd4);
    chk("k0_prga_after_ksa", t_prga - t_ksa, 32'd4);
    chk("k0_busy", {31'd0, bus.busy}, 32'd0);

    // Valid only on key 2
    valid_key = 24'd2;
    p0 = prst_cnt;
    pulse_start();
    for (int i = 0; i < 400 && !bus.found; i++) @(negedge clk);
    chk("k2_found", {31'd0, bus.found}, 32'd1);
    chk("k2_key", {8'd0, bus.secret_key}, 32'd2);
    chk("k2_prst", prst_cnt - p0, 32'd3);

    // Exhaustion at KEY_MAX = 3
    valid_en = 1'b0;
    p0 = prst_cnt;
    pulse_start();
    for (int i = 0; i < 400 && !bus.exhausted; i++) @(negedge clk);
    chk("ex_exh", {31'd0, bus.exhausted}, 32'd1);
    chk("ex_key", {8'd0, bus.secret_key}, 32'd3);
    chk("ex_prst", prst_cnt - p0, 32'd4);
    chk("ex_found", {31'd0, bus.found}, 32'd0);

    // Restart from FAIL with non-granted phases driving the bus
    bus.init_addr = 8'h10; bus.init_data = 8'hAB; bus.init_wren = 1'b1;
    bus.ksa_addr  = 8'h55; bus.ksa_data  = 8'h66; bus.ksa_wren  = 1'b1;
    model_en = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rs_busy", {31'd0, bus.busy}, 32'd1);
    chk("rs_key", {8'd0, bus.secret_key}, 32'd0);
    chk("rs_prst", {31'd0, bus.phase_rst}, 32'd1);
    chk("rs_swren_none", {31'd0, bus.s_wren}, 32'd0);
    chk("rs_saddr_none", {24'd0, bus.s_addr}, 32'd0);
    chk("rs_exh", {31'd0, bus.exhausted}, 32'd0);
    @(negedge clk);
    chk("arb_init_start", {31'd0, bus.init_start}, 32'd1);
    chk("arb_saddr", {24'd0, bus.s_addr}, 32'h10);
    chk("arb_sdata", {24'd0, bus.s_data}, 32'hAB);
    chk("arb_swren", {31'd0, bus.s_wren}, 32'd1);
    ksa_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("early_ksa_init", {31'd0, bus.init_start}, 32'd1);
    chk("early_ksa_ksa", {31'd0, bus.ksa_start}, 32'd0);
    ksa_force = 1'b0;
    model_en = 1'b1;

    // Reset mid-KSA on a non-zero key
    for (int i = 0; i < 400 && !(bus.ksa_start && bus.secret_key == 24'd2); i++) @(negedge clk);
    chk("mk_ksa", {31'd0, bus.ksa_start}, 32'd1);
    chk("mk_key", {8'd0, bus.secret_key}, 32'd2);
    chk("mk_saddr", {24'd0, bus.s_addr}, 32'h55);
    chk("mk_swren", {31'd0, bus.s_wren}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_swren", {31'd0, bus.s_wren}, 32'd0);
    chk("mr_saddr", {24'd0, bus.s_addr}, 32'd0);
    chk("mr_busy", {31'd0, bus.busy}, 32'd0);
    chk("mr_key", {8'd0, bus.secret_key}, 32'd0);
    chk("mr_ksa", {31'd0, bus.ksa_start}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("mr_idle_found", {31'd0, bus.found}, 32'd0);
    chk("mr_idle_exh", {31'd0, bus.exhausted}, 32'd0);

`ifdef SEQ_WATCHDOG_EN
    chk("wd_rst_timeout", {31'd0, bus.timeout}, 32'd0);
    ksa_block = 1'b1;
    pulse_start();
    for (int i = 0; i < 200 && !bus.exhausted; i++) @(negedge clk);
    chk("wd_exh", {31'd0, bus.exhausted}, 32'd1);
    chk("wd_timeout", {31'd0, bus.timeout}, 32'd1);
    chk("wd_cycles", t_fail - t_ksa, 32'd16);
    ksa_block = 1'b0;
    pulse_start();
    chk("wd_timeout_clr", {31'd0, bus.timeout}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
